// File: rtl/grade_pkg.sv
// Shared types and constants for the grade averager and its decoder.
// Holds the FSM state enum, grade limits and the running-sum width.
package grade_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DIVIDE  = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0] MAX_GRADE = 4'd10;
    localparam logic [3:0] FINAL_MIN = 4'd4;
    localparam logic [3:0] PASS_MIN  = 4'd7;

    localparam int SUM_W = 8;

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising pulse.
// Ports: clk, rst_n, btn_in (raw async) -> level_o (stable), pulse_o (0->1).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    // cnt_q counts consecutive cycles of disagreement; any agreement
    // (a bounce back) drops it to zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level_o = stable_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/grade_averager.sv
// Collects NGRADES grades and averages them with a repeated-subtract divider.
// Ports: clk_2, rst_n, grade_in, enter_btn, show_sit, clear ->
//        nota, situacao, count, busy, done, err.
module grade_averager
    import grade_pkg::*;
#(
    parameter int NGRADES         = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk_2,
    input  logic       rst_n,
    input  logic [3:0] grade_in,
    input  logic       enter_btn,
    input  logic       show_sit,
    input  logic       clear,
    output logic [3:0] nota,
    output logic       situacao,
    output logic [3:0] count,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0]       NG_CNT = 4'(NGRADES);
    localparam logic [SUM_W-1:0] NG_SUM = SUM_W'(NGRADES);

    logic enter_pulse;
    logic show_sit_s;
    logic enter_lvl_unused;
    logic sit_pulse_unused;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk     (clk_2),
        .rst_n   (rst_n),
        .btn_in  (enter_btn),
        .level_o (enter_lvl_unused),
        .pulse_o (enter_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sit_db (
        .clk     (clk_2),
        .rst_n   (rst_n),
        .btn_in  (show_sit),
        .level_o (show_sit_s),
        .pulse_o (sit_pulse_unused)
    );

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [3:0]       count_q, count_d;
    logic [3:0]       nota_q, nota_d;
    logic             err_q, err_d;
    logic [3:0]       quot_q, quot_d;
    logic [SUM_W-1:0] rem_q, rem_d;

    logic [SUM_W-1:0] base_sum;
    logic [SUM_W-1:0] new_sum;
    logic [3:0]       base_cnt;
    logic [3:0]       new_cnt;

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        count_d  = count_q;
        nota_d   = nota_q;
        err_d    = err_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        // A press in DONE opens a fresh set, so accumulate from zero.
        base_sum = (state_q == DONE) ? '0 : sum_q;
        base_cnt = (state_q == DONE) ? 4'd0 : count_q;
        new_sum  = base_sum + {{(SUM_W-4){1'b0}}, grade_in};
        new_cnt  = base_cnt + 4'd1;

        if (clear) begin
            state_d = COLLECT;
            sum_d   = '0;
            count_d = 4'd0;
            nota_d  = 4'd0;
            err_d   = 1'b0;
            quot_d  = 4'd0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                COLLECT, DONE: begin
                    if (enter_pulse) begin
                        state_d = COLLECT;
                        if (grade_in <= MAX_GRADE) begin
                            sum_d   = new_sum;
                            count_d = new_cnt;
                            nota_d  = grade_in;
                            err_d   = 1'b0;
                            if (new_cnt == NG_CNT) begin
                                state_d = DIVIDE;
                                rem_d   = new_sum;
                                quot_d  = 4'd0;
                            end
                        end else begin
                            sum_d   = base_sum;
                            count_d = base_cnt;
                            err_d   = 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    if (rem_q >= NG_SUM) begin
                        rem_d  = rem_q - NG_SUM;
                        quot_d = quot_q + 4'd1;
                    end else begin
                        nota_d  = quot_q;
                        state_d = DONE;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            sum_q   <= '0;
            count_q <= 4'd0;
            nota_q  <= 4'd0;
            err_q   <= 1'b0;
            quot_q  <= 4'd0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            nota_q  <= nota_d;
            err_q   <= err_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign nota     = nota_q;
    assign count    = count_q;
    assign err      = err_q;
    assign busy     = (state_q == DIVIDE);
    assign done     = (state_q == DONE);
    assign situacao = (state_q == DONE) && show_sit_s;

endmodule

// File: tb/tb_grade_averager.sv
// Directed bench for grade_averager (NGRADES=4), plus a fast-debounce
// instance used to land a press inside the divide window.
module tb_grade_averager;

    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic [3:0] grade_in;
    logic       enter_btn;
    logic       show_sit;
    logic       clear;
    logic [3:0] nota;
    logic       situacao;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       err;

    logic [3:0] f_grade;
    logic       f_btn;
    logic [3:0] f_nota;
    logic       f_sit;
    logic [3:0] f_count;
    logic       f_busy;
    logic       f_done;
    logic       f_err;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cyc;
    bit seen;

    always #5 clk_2 = ~clk_2;

    grade_averager #(.NGRADES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk_2     (clk_2),
        .rst_n     (rst_n),
        .grade_in  (grade_in),
        .enter_btn (enter_btn),
        .show_sit  (show_sit),
        .clear     (clear),
        .nota      (nota),
        .situacao  (situacao),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    grade_averager #(.NGRADES(4), .DEBOUNCE_CYCLES(1)) dut_fast (
        .clk_2     (clk_2),
        .rst_n     (rst_n),
        .grade_in  (f_grade),
        .enter_btn (f_btn),
        .show_sit  (1'b0),
        .clear     (1'b0),
        .nota      (f_nota),
        .situacao  (f_sit),
        .count     (f_count),
        .busy      (f_busy),
        .done      (f_done),
        .err       (f_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Clean press: 14 cycles high, 14 low; counts busy cycles seen.
    task automatic press(input logic [3:0] g);
        grade_in  = g;
        enter_btn = 1'b1;
        busy_cyc  = 0;
        repeat (14) begin
            @(negedge clk_2);
            if (busy) busy_cyc++;
        end
        enter_btn = 1'b0;
        repeat (14) begin
            @(negedge clk_2);
            if (busy) busy_cyc++;
        end
    endtask

    task automatic do_clear();
        @(negedge clk_2);
        clear = 1'b1;
        @(negedge clk_2);
        clear = 1'b0;
    endtask

    task automatic fpress(input logic [3:0] g);
        f_grade = g;
        f_btn   = 1'b1;
        repeat (6) @(negedge clk_2);
        f_btn = 1'b0;
        repeat (6) @(negedge clk_2);
    endtask

    initial begin
        rst_n     = 1'b0;
        grade_in  = 4'd0;
        enter_btn = 1'b0;
        show_sit  = 1'b0;
        clear     = 1'b0;
        f_grade   = 4'd0;
        f_btn     = 1'b0;
        repeat (3) @(negedge clk_2);
        rst_n = 1'b1;

        // Idle after reset
        repeat (20) begin
            @(negedge clk_2);
            check("idle_outs", {nota, situacao, count, busy, done, err}, 0);
        end

        // Bounce rejection
        grade_in = 4'd3;
        repeat (10) begin
            enter_btn = ~enter_btn;
            repeat (3) @(negedge clk_2);
        end
        check("bounce_none", count, 0);
        press(4'd3);
        check("bounce_once", count, 1);
        do_clear();
        check("clear_cnt", count, 0);

        // Average 7,8,6,9 -> 30/4 = 7
        press(4'd7);
        press(4'd8);
        press(4'd6);
        check("avg_cnt3", count, 3);
        check("avg_nota6", nota, 6);
        press(4'd9);
        check("avg_busy", busy_cyc, 8);
        check("avg_done", done, 1);
        check("avg_nota", nota, 7);
        show_sit = 1'b1;
        repeat (14) @(negedge clk_2);
        check("sit_on", situacao, 1);
        show_sit = 1'b0;
        repeat (14) @(negedge clk_2);
        check("sit_off", situacao, 0);
        check("avg_hold", nota, 7);

        // Illegal grade
        do_clear();
        press(4'd3);
        press(4'd12);
        check("ill_err", err, 1);
        check("ill_cnt", count, 1);
        check("ill_nota", nota, 3);
        press(4'd5);
        check("ok_err", err, 0);
        check("ok_cnt", count, 2);
        check("ok_nota", nota, 5);
        press(4'd4);
        press(4'd4);
        check("avg16_busy", busy_cyc, 5);
        check("avg16_nota", nota, 4);

        // Press in DONE opens a new set
        press(4'd2);
        check("new_cnt", count, 1);
        check("new_nota", nota, 2);
        check("new_done", done, 0);

        // All-zero set
        do_clear();
        repeat (4) press(4'd0);
        check("zero_busy", busy_cyc, 1);
        check("zero_nota", nota, 0);
        check("zero_done", done, 1);

        // All-ten set
        do_clear();
        repeat (4) press(4'd10);
        check("ten_busy", busy_cyc, 11);
        check("ten_nota", nota, 10);
        check("ten_done", done, 1);

        // clear overlapping the enter pulse
        do_clear();
        press(4'd3);
        check("ce_pre", count, 1);
        grade_in  = 4'd6;
        enter_btn = 1'b1;
        repeat (8) @(negedge clk_2);
        clear = 1'b1;
        repeat (5) @(negedge clk_2);
        clear = 1'b0;
        repeat (14) @(negedge clk_2);
        enter_btn = 1'b0;
        repeat (14) @(negedge clk_2);
        check("ce_cnt", count, 0);
        check("ce_nota", nota, 0);
        check("ce_state", {busy, done}, 0);

        // Press during DIVIDE is dropped (fast-debounce instance)
        repeat (3) fpress(4'd10);
        f_btn = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk_2);
            if (f_busy) seen = 1'b1;
        end
        check("fdiv_seen", seen, 1);
        f_btn = 1'b0;
        repeat (3) @(negedge clk_2);
        f_grade = 4'd3;
        f_btn   = 1'b1;
        check("fdiv_busy", f_busy, 1);
        repeat (20) @(negedge clk_2);
        f_btn = 1'b0;
        repeat (6) @(negedge clk_2);
        check("fdiv_cnt", f_count, 4);
        check("fdiv_nota", f_nota, 10);
        check("fdiv_done", f_done, 1);

        // Reset in the middle of DIVIDE
        do_clear();
        repeat (3) press(4'd10);
        grade_in  = 4'd10;
        enter_btn = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk_2);
            if (busy) seen = 1'b1;
        end
        check("rst_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_nota", nota, 0);
        check("rst_cnt", count, 0);
        enter_btn = 1'b0;
        repeat (3) @(negedge clk_2);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_2);
        check("rst_after", {nota, count, busy, done, err}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
